stack_unit: RTL

- Hardware operand stack for the 8-bit stack-machine CPU.
- Responds to the `push`/`pop` strobes that the multicycle control unit issues through the datapath.
- Presents top-of-stack (`tos`) and a zero flag back to the datapath and control.
- Single-cycle responder: commands are accepted every cycle, there is no backpressure, and status is reported through flags.

---
 rtl/stack_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// +----------------------------------------------------------------------------+
// | Module     : stack_unit                                                    |
// | Description: LIFO operand stack with sticky overflow/underflow flags.      |
// |              Define STACK_NOS_EN to add the nos output and swap command.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
`ifdef STACK_NOS_EN
  input  logic             swap,
  output logic [WIDTH-1:0] nos,
`endif
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic             tos_zero,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_sp;
  logic             r_ovf;
  logic             r_udf;

  logic             w_empty;
  logic             w_full;
  logic [c_AW-1:0]  w_top_idx;
  logic [c_AW-1:0]  w_push_idx;
  logic [c_AW-1:0]  w_wr_idx;
  logic             w_wr_en;
  logic [CW-1:0]    w_sp_next;
  logic             w_set_ovf;
  logic             w_set_udf;
  logic             w_cmd_ok;
`ifdef STACK_NOS_EN
  localparam logic [CW-1:0] c_TWO = CW'(2);
  logic [c_AW-1:0]  w_nos_idx;
  logic             w_swap_en;
  assign w_nos_idx = c_AW'(r_sp - c_TWO);
`endif

  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == c_DEPTH);
  assign w_top_idx  = c_AW'(r_sp - c_ONE);
  assign w_push_idx = c_AW'(r_sp);
  assign w_cmd_ok   = !rst && !clear;

  always_comb begin
    w_sp_next = r_sp;
    w_wr_en   = 1'b0;
    w_wr_idx  = w_top_idx;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
`ifdef STACK_NOS_EN
    w_swap_en = 1'b0;
`endif
    case ({push, pop})
      2'b10: begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_idx  = w_push_idx;
          w_sp_next = r_sp + c_ONE;
        end
      end
      2'b01: begin
        if (w_empty) w_set_udf = 1'b1;
        else         w_sp_next = r_sp - c_ONE;
      end
      2'b11: begin
        // Replace-top; on an empty stack this degenerates into a plain push.
        w_wr_en = 1'b1;
        if (w_empty) begin
          w_wr_idx  = w_push_idx;
          w_sp_next = c_ONE;
        end
      end
      default: begin
`ifdef STACK_NOS_EN
        if (swap) begin
          if (r_sp < c_TWO) w_set_udf = 1'b1;
          else              w_swap_en = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_sp <= w_sp_next;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_udf) r_udf <= 1'b1;
    end
  end

  // Storage has no reset; contents are only visible through a valid sp.
  always_ff @(posedge clk) begin
    if (w_cmd_ok) begin
      if (w_wr_en) r_mem[w_wr_idx] <= din;
`ifdef STACK_NOS_EN
      if (w_swap_en) begin
        r_mem[w_top_idx] <= r_mem[w_nos_idx];
        r_mem[w_nos_idx] <= r_mem[w_top_idx];
      end
`endif
    end
  end

  assign tos       = w_empty ? '0 : r_mem[w_top_idx];
  assign tos_zero  = (tos == '0);
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_sp;
  assign overflow  = r_ovf;
  assign underflow = r_udf;
`ifdef STACK_NOS_EN
  assign nos = (r_sp >= c_TWO) ? r_mem[w_nos_idx] : '0;
`endif

endmodule

`default_nettype wire
